// File: rtl/psum_collector_pkg.sv
// Shared defaults and sizing helpers for the psum collector.
package psum_collector_pkg;

  localparam int unsigned default_col     = 8;
  localparam int unsigned default_psum_bw = 16;
  localparam int unsigned default_depth   = 8;

  // Occupancy counter must represent 0..depth inclusive.
  function automatic int unsigned count_width(input int unsigned d);
    return $clog2(d) + 1;
  endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// Single-column first-word-fall-through FIFO with a held output while the row is not shown.
module psum_col_fifo
  import psum_collector_pkg::*;
#(
  parameter int unsigned psum_bw = default_psum_bw,
  parameter int unsigned depth   = default_depth
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] wdata,
  input  logic               wr,
  input  logic               pop,
  input  logic               show,
  output logic [psum_bw-1:0] rdata_c,
  output logic               nonempty_c,
  output logic               full_c,
  output logic               drop_c
);

  localparam int unsigned aw = $clog2(depth);
  localparam int unsigned cw = count_width(depth);

  logic [psum_bw-1:0] mem [depth];
  logic [psum_bw-1:0] last;
  logic [aw-1:0]      wptr;
  logic [aw-1:0]      rptr;
  logic [cw-1:0]      count;
  logic               push;
  logic               pop_ok;

  always_comb begin
    nonempty_c = (count != '0);
    full_c     = (count == cw'(depth));
    pop_ok     = pop && nonempty_c;
    push       = wr && (!full_c || pop_ok);
    drop_c     = wr && full_c && !pop_ok;
    rdata_c    = show ? mem[rptr] : last;
  end

  // Pointers wrap naturally because depth is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + aw'(1);
      if (pop_ok) rptr <= rptr + aw'(1);
      if (push && !pop_ok)      count <= count + cw'(1);
      else if (!push && pop_ok) count <= count - cw'(1);
    end
  end

  // Storage and the output hold register carry no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= wdata;
    if (show) last <= mem[rptr];
  end

endmodule

// File: rtl/psum_collector.sv
// Collects skewed psum columns from the array south edge into per-column FIFOs, popped as whole rows.
module psum_collector
  import psum_collector_pkg::*;
#(
  parameter int unsigned col     = default_col,
  parameter int unsigned psum_bw = default_psum_bw,
  parameter int unsigned depth   = default_depth
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [psum_bw*col-1:0] in_psum,
  input  logic [col-1:0]         in_valid,
  input  logic                   rd,
  output logic [psum_bw*col-1:0] out_data,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_overflow
);

  logic [col-1:0] nonempty;
  logic [col-1:0] full;
  logic [col-1:0] drop;
  logic           pop;

  assign o_valid = &nonempty;
  assign o_full  = |full;
  assign pop     = rd && o_valid;

  for (genvar c = 0; c < col; c++) begin : g_col
    psum_col_fifo #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .wdata     (in_psum[c*psum_bw +: psum_bw]),
      .wr        (in_valid[c]),
      .pop       (pop),
      .show      (o_valid),
      .rdata_c   (out_data[c*psum_bw +: psum_bw]),
      .nonempty_c(nonempty[c]),
      .full_c    (full[c]),
      .drop_c    (drop[c])
    );
  end

  // Sticky until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     o_overflow <= 1'b0;
    else if (|drop) o_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector with default parameters (8 columns, 16-bit psums, depth 8).
module tb_psum_collector;

  logic         clk;
  logic         reset;
  logic [127:0] in_psum;
  logic [7:0]   in_valid;
  logic         rd;
  logic [127:0] out_data;
  logic         o_valid;
  logic         o_full;
  logic         o_overflow;

  int checks;
  int failures;

  psum_collector dut (
    .clk       (clk),
    .reset     (reset),
    .in_psum   (in_psum),
    .in_valid  (in_valid),
    .rd        (rd),
    .out_data  (out_data),
    .o_valid   (o_valid),
    .o_full    (o_full),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] row_of(input int r);
    logic [127:0] v;
    v = '0;
    for (int c = 0; c < 8; c++) v[c*16 +: 16] = 16'((r << 8) | c);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r);
    in_psum  = row_of(r);
    in_valid = 8'hFF;
    tick();
    in_valid = 8'h00;
  endtask

  task automatic pop_row();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [127:0] exp_skew;
    checks   = 0;
    failures = 0;
    exp_skew = 128'h0017_0016_0015_0014_0013_0012_0011_0010;
    reset    = 1'b0;
    in_psum  = '0;
    in_valid = '0;
    rd       = 1'b0;

    // Reset state, before any clock edge
    #1;
    chk("reset_valid", 128'(o_valid), 128'(1'b0));
    chk("reset_full", 128'(o_full), 128'(1'b0));
    chk("reset_ovf", 128'(o_overflow), 128'(1'b0));
    #12;
    reset = 1'b1;
    tick();

    // Empty read
    rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("empty_rd_valid", 128'(o_valid), 128'(1'b0));
      chk("empty_rd_count", 128'(dut.g_col[0].u_fifo.count), 128'(0));
    end
    rd = 1'b0;
    chk("empty_rd_ovf", 128'(o_overflow), 128'(1'b0));

    // Skewed fill
    for (int c = 0; c < 8; c++) begin
      in_psum  = '0;
      in_psum[c*16 +: 16] = 16'(16'h0010 + c);
      in_valid = 8'(1 << c);
      tick();
      chk($sformatf("skew_valid_c%0d", c), 128'(o_valid), 128'(c == 7));
    end
    in_valid = '0;
    chk("skew_data", out_data, exp_skew);
    pop_row();
    chk("skew_pop_valid", 128'(o_valid), 128'(1'b0));
    chk("skew_hold_data", out_data, exp_skew);

    // Fill to full, then overflow on column 0
    for (int r = 0; r < 8; r++) write_row(r);
    chk("full_full", 128'(o_full), 128'(1'b1));
    chk("full_valid", 128'(o_valid), 128'(1'b1));
    chk("full_ovf_pre", 128'(o_overflow), 128'(1'b0));
    in_psum  = row_of(99);
    in_valid = 8'h01;
    tick();
    in_valid = '0;
    chk("full_ovf_set", 128'(o_overflow), 128'(1'b1));
    chk("full_count0", 128'(dut.g_col[0].u_fifo.count), 128'(8));
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("full_pop_r%0d", r), out_data, row_of(r));
      pop_row();
    end
    chk("full_drained_valid", 128'(o_valid), 128'(1'b0));
    chk("full_drained_full", 128'(o_full), 128'(1'b0));
    chk("ovf_sticky", 128'(o_overflow), 128'(1'b1));
    pulse_reset();
    chk("ovf_cleared", 128'(o_overflow), 128'(1'b0));
    tick();

    // Push and pop on the same edge while full
    for (int r = 0; r < 8; r++) write_row(r);
    in_psum  = row_of(8);
    in_valid = 8'hFF;
    rd       = 1'b1;
    tick();
    in_valid = '0;
    rd       = 1'b0;
    chk("pp_full", 128'(o_full), 128'(1'b1));
    chk("pp_ovf", 128'(o_overflow), 128'(1'b0));
    chk("pp_count0", 128'(dut.g_col[0].u_fifo.count), 128'(8));
    chk("pp_count7", 128'(dut.g_col[7].u_fifo.count), 128'(8));
    for (int r = 1; r <= 8; r++) begin
      chk($sformatf("pp_pop_r%0d", r), out_data, row_of(r));
      pop_row();
    end
    chk("pp_empty", 128'(o_valid), 128'(1'b0));

    // Streaming with rd held high across two pointer wraps
    rd = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      in_psum  = row_of(10 + k);
      in_valid = (k < 20) ? 8'hFF : 8'h00;
      if (k > 0) begin
        chk($sformatf("wrap_valid_k%0d", k), 128'(o_valid), 128'(1'b1));
        chk($sformatf("wrap_data_k%0d", k), out_data, row_of(10 + k - 1));
      end
      tick();
    end
    rd       = 1'b0;
    in_valid = '0;
    chk("wrap_empty", 128'(o_valid), 128'(1'b0));
    chk("wrap_ovf", 128'(o_overflow), 128'(1'b0));

    // Mid-run reset with 3 rows queued and the overflow flag set
    for (int r = 0; r < 8; r++) write_row(40 + r);
    in_valid = 8'h80;
    tick();
    in_valid = '0;
    for (int r = 0; r < 5; r++) pop_row();
    chk("mid_pre_valid", 128'(o_valid), 128'(1'b1));
    chk("mid_pre_ovf", 128'(o_overflow), 128'(1'b1));
    reset = 1'b0;
    #1;
    chk("mid_valid", 128'(o_valid), 128'(1'b0));
    chk("mid_full", 128'(o_full), 128'(1'b0));
    chk("mid_ovf", 128'(o_overflow), 128'(1'b0));
    #3;
    reset = 1'b1;
    in_psum = row_of(50);
    for (int c = 0; c < 8; c++) begin
      in_valid = 8'(1 << c);
      tick();
    end
    in_valid = '0;
    chk("mid_after_valid", 128'(o_valid), 128'(1'b1));
    chk("mid_after_data", out_data, row_of(50));
    pop_row();
    chk("mid_after_empty", 128'(o_valid), 128'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_collector.md
PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 Parameter: col, 8, number of array columns collected.
REQ-002 Parameter: psum_bw, 16, width of one partial sum.
REQ-003 Parameter: depth, 8, entries per column queue; power of two, at least 2.
REQ-004 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-005 Port: reset  input  1  asynchronous, active-low; low clears all state immediately.
REQ-006 Port: in_psum  input  psum_bw*col  psum row from the array south edge; column c occupies bits [c*psum_bw +: psum_bw].
REQ-007 Port: in_valid  input  col  per-column write strobe; columns arrive skewed by one cycle per column.
REQ-008 Port: rd  input  1  pop request for one complete psum row.
REQ-009 Port: out_data  output  psum_bw*col  head entry of every column queue, using the same column packing as in_psum.
REQ-010 Port: o_valid  output  1  high when every column queue holds at least one entry.
REQ-011 Port: o_full  output  1  high when any column queue holds depth entries.
REQ-012 Port: o_overflow  output  1  sticky flag; set when a write strobe is dropped.

Function
REQ-013 The block SHALL keep one independent FIFO per column, with its own write pointer, read pointer and a count of width clog2(depth)+1.
REQ-014 Column c SHALL accept in_psum slice c on the edge where in_valid[c]=1, if its count < depth or a pop occurs on the same edge.
REQ-015 A write to a full column with no pop on that edge SHALL be dropped, SHALL leave that column unchanged, and SHALL set o_overflow on that edge.
REQ-016 o_overflow SHALL stay set until reset.
REQ-017 Pop SHALL be rd && o_valid; a pop SHALL advance the read pointer of every column on the same edge.
REQ-018 rd while o_valid=0 SHALL be ignored, with no state change and no flag.
REQ-019 out_data SHALL be first-word-fall-through: combinationally equal to the head entries whenever o_valid=1.
REQ-020 out_data SHALL hold its last value while o_valid=0; it is don't-care before the first write.
REQ-021 Latency: a row whose last (highest-skew) column is written at edge N SHALL make o_valid=1 after edge N, provided all earlier rows have been popped.
REQ-022 A simultaneous push and pop on one column SHALL leave its count unchanged, and data SHALL stay in order.
REQ-023 Pointers SHALL wrap from depth-1 to 0 with no gap or duplicate entry.
REQ-024 o_valid and o_full SHALL be decoded from the registered counts only, with no combinational path from rd or in_valid.
REQ-025 Entries SHALL be stored and output unmodified, with no sign or width conversion.

Reset
REQ-026 While reset=0, all counts and pointers SHALL be 0, o_valid=0, o_full=0 and o_overflow=0, regardless of clk.
REQ-027 Storage contents SHALL NOT need to be reset.
REQ-028 Reset asserted mid-operation SHALL discard all queued rows.
REQ-029 The first write SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-030 col, psum_bw and depth defaults, plus the count-width function, SHALL live in the shared project package.
REQ-031 The block SHALL use one sub-module, psum_col_fifo (a single-column FWFT FIFO), instantiated col times in a generate loop.
REQ-032 Top-level logic SHALL be limited to the AND of column non-empty flags, the OR of full flags, and the overflow register.

Verification
REQ-033 Skewed fill: write 0x0010+c to column c at edge c for c=0..7 -> o_valid rises only after edge 7; out_data = {0x0017,...,0x0010}.
REQ-034 Fill to full: 8 complete rows with no rd -> o_full=1; a 9th write to column 0 is dropped; o_overflow=1; the rows pop back in order 0..7.
REQ-035 Push and pop together: with all columns full, rd=1 and in_valid=0xFF on the same edge -> counts stay 8, o_overflow stays 0, next head is row 1.
REQ-036 Empty read: rd=1 for 3 cycles after reset -> o_valid stays 0, counts stay 0, no flag set.
REQ-037 Wrap-around: stream 20 rows with rd held high -> every row appears exactly once, in order, across two pointer wraps.
REQ-038 Mid-run reset: reset low for half a cycle with 3 rows queued -> o_valid=0, o_full=0, o_overflow=0 immediately; the next complete write is output first.
